r5_par2ser: RTL and testbench

Parallel-to-serial commutator for the Radix-5 FFT datapath. It accepts one complete 5-point butterfly result, five complex samples presented in parallel, in a single handshake. It then streams those samples out one per cycle, X0 first, on a valid/ready serial interface. The block sits between the radix-5 butterfly and the downstream serial stage or output port. It is the serializing counterpart of the input-side sample buffering and alignment delays.

---
 rtl/r5_par2ser_pkg.sv | 17 +
 rtl/r5_par2ser_cplx_reg.sv | 26 ++
 rtl/r5_par2ser.sv | 101 ++++++++++
 tb/tb_r5_par2ser.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/r5_par2ser_pkg.sv
// Shared constants, FSM state type and small helpers for the radix-5 commutator.
package r5_pkg;

    localparam int R5_NPT   = 5;
    localparam int R5_IDX_W = 3;
    localparam int R5_DW    = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } r5_state_e;

    function automatic logic [R5_IDX_W-1:0] r5_last_idx(input int npt);
        return R5_IDX_W'(npt - 1);
    endfunction

endpackage

// File: rtl/r5_par2ser_cplx_reg.sv
// Complex sample register (re/img pair) with load enable.
// Latency: q updates one edge after load; async reset clears to 0.
// Backpressure: none, holds value whenever load is low.
module r5_cplx_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] d_re,
    input  logic [DW-1:0] d_img,
    output logic [DW-1:0] q_re,
    output logic [DW-1:0] q_img
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_re  <= '0;
            q_img <= '0;
        end else if (load) begin
            q_re  <= d_re;
            q_img <= d_img;
        end
    end

endmodule

// File: rtl/r5_par2ser.sv
// Radix-5 parallel-to-serial commutator: one 5-sample frame in, X0..X4 out serially.
// Latency: X0 is valid right after the accepting edge, then one sample per cycle.
// Backpressure: out_ready low freezes outputs; a new frame is taken only with X4 leaving or when idle.
module r5_par2ser
    import r5_pkg::*;
#(
    parameter int DW  = R5_DW,
    parameter int NPT = R5_NPT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NPT*DW-1:0]   x_re,
    input  logic [NPT*DW-1:0]   x_img,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       y_re,
    output logic [DW-1:0]       y_img,
    output logic [R5_IDX_W-1:0] y_idx,
    output logic                y_last
);

    localparam logic [R5_IDX_W-1:0] IDX_LAST = r5_last_idx(NPT);

    r5_state_e             state;
    logic [R5_IDX_W-1:0]   idx;
    logic [DW-1:0]         bank_re  [NPT];
    logic [DW-1:0]         bank_img [NPT];
    logic                  at_last;
    logic                  in_fire;
    logic                  out_fire;

    assign at_last   = (idx == IDX_LAST);
    assign out_valid = (state == ST_SHIFT);
    // Refill is only allowed while the final sample is actually leaving.
    assign in_ready  = !rst && ((state == ST_IDLE) ||
                                ((state == ST_SHIFT) && at_last && out_ready));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    for (genvar k = 0; k < NPT; k++) begin : g_bank
        r5_cplx_reg #(.DW(DW)) u_reg (
            .clk   (clk),
            .rst   (rst),
            .load  (in_fire),
            .d_re  (x_re[k*DW +: DW]),
            .d_img (x_img[k*DW +: DW]),
            .q_re  (bank_re[k]),
            .q_img (bank_img[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        state <= ST_SHIFT;
                        idx   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (out_fire) begin
                        if (at_last) begin
                            idx <= '0;
                            if (!in_fire) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Output is a pure register mux; x_* never reaches y_* combinationally.
    always_comb begin
        y_re  = '0;
        y_img = '0;
        for (int k = 0; k < NPT; k++) begin
            if (idx == R5_IDX_W'(k)) begin
                y_re  = bank_re[k];
                y_img = bank_img[k];
            end
        end
    end

    assign y_idx  = idx;
    assign y_last = out_valid && at_last;

endmodule

// File: tb/tb_r5_par2ser.sv
// Bench for r5_par2ser: directed scenarios plus random traffic against a queue-based frame model.
module tb_r5_par2ser;

    localparam int DW  = 32;
    localparam int NPT = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [NPT*DW-1:0] x_re = '0;
    logic [NPT*DW-1:0] x_img = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DW-1:0]     y_re;
    logic [DW-1:0]     y_img;
    logic [2:0]        y_idx;
    logic              y_last;

    r5_par2ser #(.DW(DW), .NPT(NPT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_re      (x_re),
        .x_img     (x_img),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_re      (y_re),
        .y_img     (y_img),
        .y_idx     (y_idx),
        .y_last    (y_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] re;
        logic [31:0] img;
        logic [2:0]  idx;
    } samp_t;

    samp_t       exp_q[$];
    logic [31:0] fr_re  [NPT];
    logic [31:0] fr_img [NPT];
    int          checks = 0;
    int          errors = 0;
    bit          acc;
    bit          acc_y_last;
    int          cyc_cnt;
    int          vld_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // A frame may enter when nothing is pending, or when only the last sample remains and it leaves now.
    function automatic bit exp_in_ready();
        return !rst && ((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
    endfunction

    task automatic pack_frame();
        for (int k = 0; k < NPT; k++) begin
            x_re[k*DW +: DW]  = fr_re[k];
            x_img[k*DW +: DW] = fr_img[k];
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < NPT; k++) begin
            fr_re[k]  = $urandom;
            fr_img[k] = $urandom;
        end
        pack_frame();
    endtask

    // Starts at posedge+1 with inputs set; checks, crosses one edge, updates the model.
    task automatic cycle();
        bit    fo;
        bit    fi;
        samp_t s;
        #1;
        chk("in_ready", 64'(in_ready), 64'(exp_in_ready()));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("y_re", 64'(y_re), 64'(exp_q[0].re));
            chk("y_img", 64'(y_img), 64'(exp_q[0].img));
            chk("y_idx", 64'(y_idx), 64'(exp_q[0].idx));
            chk("y_last", 64'(y_last), 64'(exp_q[0].idx == 3'd4));
        end else begin
            chk("y_last_idle", 64'(y_last), 64'd0);
        end
        fo = (exp_q.size() > 0) && out_ready;
        fi = in_valid && exp_in_ready();
        if (fi) acc_y_last = y_last;
        cyc_cnt++;
        if (out_valid) vld_cnt++;
        @(posedge clk);
        if (fo) void'(exp_q.pop_front());
        if (fi) begin
            for (int k = 0; k < NPT; k++) begin
                s.re  = fr_re[k];
                s.img = fr_img[k];
                s.idx = 3'(k);
                exp_q.push_back(s);
            end
        end
        acc = fi;
        #1;
    endtask

    task automatic send_frame(input bit keep_valid);
        int n;
        n = 0;
        in_valid = 1'b1;
        acc = 1'b0;
        while (!acc && n < 40) begin
            cycle();
            n++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            cycle();
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 64'd0, 64'd1);
        cycle();
    endtask

    task automatic run_until_idx(input logic [2:0] target);
        int n;
        n = 0;
        while (!(exp_q.size() > 0 && exp_q[0].idx == target) && n < 20) begin
            cycle();
            n++;
        end
        if (n >= 20) chk("idx_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        // Reset state while rst is held
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_y_re", 64'(y_re), 64'd0);
        chk("rst_y_img", 64'(y_img), 64'd0);
        chk("rst_y_idx", 64'(y_idx), 64'd0);
        chk("rst_y_last", 64'(y_last), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Single frame with a known ramp
        out_ready = 1'b1;
        for (int k = 0; k < NPT; k++) begin
            fr_re[k]  = 32'(100 + k);
            fr_img[k] = 32'(-(k + 1));
        end
        pack_frame();
        send_frame(1'b0);
        drain();

        // Back-to-back frames: 10 samples without a bubble
        rand_frame();
        send_frame(1'b1);
        cyc_cnt = 0;
        vld_cnt = 0;
        acc_y_last = 1'b0;
        rand_frame();
        send_frame(1'b0);
        chk("b2b_accept_on_x4", 64'(acc_y_last), 64'd1);
        drain();
        chk("b2b_valid_count", 64'(vld_cnt), 64'd10);
        chk("b2b_cycle_count", 64'(cyc_cnt), 64'd11);

        // Backpressure at sample 2, next frame waiting upstream
        rand_frame();
        send_frame(1'b0);
        run_until_idx(3'd2);
        out_ready = 1'b0;
        rand_frame();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_y_idx", 64'(y_idx), 64'd2);
        end
        out_ready = 1'b1;
        send_frame(1'b0);
        drain();

        // Reset in the middle of a frame
        rand_frame();
        send_frame(1'b0);
        run_until_idx(3'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_y_re", 64'(y_re), 64'd0);
        chk("midrst_y_img", 64'(y_img), 64'd0);
        chk("midrst_y_idx", 64'(y_idx), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_frame();
        send_frame(1'b0);
        drain();

        // Extreme two's complement patterns pass through bit-exact
        fr_re[0] = 32'h7FFF_FFFF; fr_img[0] = 32'h8000_0000;
        fr_re[1] = 32'h8000_0000; fr_img[1] = 32'h7FFF_FFFF;
        fr_re[2] = 32'hFFFF_FFFF; fr_img[2] = 32'h0000_0001;
        fr_re[3] = 32'h0000_0001; fr_img[3] = 32'hFFFF_FFFF;
        fr_re[4] = 32'h8000_0001; fr_img[4] = 32'h7FFF_FFFE;
        pack_frame();
        send_frame(1'b0);
        drain();

        // Random traffic with random downstream stalls
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 2) == 0) begin
                rand_frame();
                in_valid = 1'b1;
            end
            cycle();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
